// File: rtl/ieee754_pkg.sv
// rtl/ieee754_pkg.sv - shared constants, fp32 field layout and divider states
package ieee754_pkg;

    localparam int          EXP_BIAS = 127;
    localparam logic [31:0] QNAN     = 32'h7FC00000;
    localparam logic [31:0] POS_INF  = 32'h7F800000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        NORM,
        DONE
    } div_state_t;

endpackage

// File: rtl/ieee754_classify.sv
// rtl/ieee754_classify.sv - combinational operand class flags (exponent 0 flushes to zero)
module ieee754_classify
    import ieee754_pkg::*;
(
    input  logic [31:0] op,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan
);

    fp32_t f;
    assign f = op;

    assign is_zero = (f.exp == 8'h00);
    assign is_inf  = (f.exp == 8'hFF) && (f.frac == 23'd0);
    assign is_nan  = (f.exp == 8'hFF) && (f.frac != 23'd0);

endmodule

// File: rtl/ieee754_divider.sv
// rtl/ieee754_divider.sv - iterative fp32 divider, one restoring quotient bit per cycle
// Build option: IEEE754_DIV_ROUND_EN selects round-to-nearest-even instead of truncation.
module ieee754_divider
    import ieee754_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] input_a,
    input  logic [31:0] input_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    div_state_t        state, state_nxt;
    fp32_t             a, b;
    logic              a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic              special;
    logic [31:0]       special_res;
    logic              res_sign;

    logic [23:0]       div_m;
    logic [24:0]       rem, rem_diff, rem_sel, rem_nxt;
    logic [25:0]       quo;
    logic [4:0]        cnt;
    logic signed [9:0] exp_q, exp_n, exp_r;
    logic              sign_q;
    logic [31:0]       result_q, norm_res;

    logic              take;
    logic [24:0]       qn;
    logic              guard, sticky, round_inc;
    logic [23:0]       mant_r;

    assign a = input_a;
    assign b = input_b;

    ieee754_classify u_cls_a (.op(input_a), .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan));
    ieee754_classify u_cls_b (.op(input_b), .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan));

    assign res_sign = a.sign ^ b.sign;
    assign special  = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;

    always_comb begin
        special_res = {res_sign, 31'd0};
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
            special_res = QNAN;
        else if (a_inf || b_zero)
            special_res = {res_sign, POS_INF[30:0]};
    end

    // Restoring step: remainder stays below twice the divisor, so 25 bits suffice.
    assign take     = (rem >= {1'b0, div_m});
    assign rem_diff = rem - {1'b0, div_m};
    assign rem_sel  = take ? rem_diff : rem;
    assign rem_nxt  = rem_sel << 1;

    assign qn     = quo[25] ? quo[24:0] : {quo[23:0], 1'b0};
    assign exp_n  = quo[25] ? exp_q : exp_q - 10'sd1;
    assign guard  = qn[1];
    assign sticky = qn[0] | (|rem);

`ifdef IEEE754_DIV_ROUND_EN
    assign round_inc = guard & (sticky | qn[2]);
`else
    logic unused_round;
    assign unused_round = &{1'b0, guard, sticky};
    assign round_inc    = 1'b0;
`endif

    // A carry out of the significand leaves frac at zero and bumps the exponent.
    assign mant_r = {1'b0, qn[24:2]} + {23'd0, round_inc};
    assign exp_r  = exp_n + (mant_r[23] ? 10'sd1 : 10'sd0);

    always_comb begin
        norm_res = {sign_q, exp_r[7:0], mant_r[22:0]};
        if (exp_r >= 10'sd255)
            norm_res = {sign_q, POS_INF[30:0]};
        else if (exp_r <= 10'sd0)
            norm_res = {sign_q, 31'd0};
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = special ? DONE : DIVIDE;
            end
            DIVIDE: if (cnt == 5'd25) state_nxt = NORM;
            NORM:   state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            quo      <= '0;
            rem      <= '0;
            cnt      <= '0;
            div_m    <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (in_valid) begin
                    sign_q <= res_sign;
                    exp_q  <= 10'(a.exp) - 10'(b.exp) + 10'(EXP_BIAS);
                    rem    <= {2'b01, a.frac};
                    div_m  <= {1'b1, b.frac};
                    quo    <= '0;
                    cnt    <= '0;
                    if (special)
                        result_q <= special_res;
                end
                DIVIDE: begin
                    quo <= {quo[24:0], take};
                    rem <= rem_nxt;
                    cnt <= cnt + 5'd1;
                end
                NORM:    result_q <= norm_res;
                default: ;
            endcase
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_ieee754_divider.sv
// tb/tb_ieee754_divider.sv - directed self-checking bench for ieee754_divider
module tb_ieee754_divider;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] input_a = 32'd0;
    logic [31:0] input_b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;

    int n_pass  = 0;
    int n_total = 0;

    ieee754_divider dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .input_a   (input_a),
        .input_b   (input_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat);
        int lat;
        input_a  = a;
        input_b  = b;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        input_a  = 32'hDEADBEEF;
        input_b  = 32'h12345678;
        check32({tag, "_in_ready_busy"}, {31'd0, in_ready}, 32'd0);
        lat = 1;
        while (!out_valid && lat < 60) begin
            cycle();
            lat++;
        end
        check_int({tag, "_latency"}, out_valid ? lat : -1, exp_lat);
        check32({tag, "_result"}, result, exp_res);
        cycle();
    endtask

    initial begin
        logic [31:0] hold_res;
        int          lat;

        repeat (3) cycle();
        check32("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check32("reset_result", result, 32'h00000000);
        check32("reset_in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b1;
        cycle();

        run_op("div_6_2",     32'h40C00000, 32'h40000000, 32'h40400000, 28);
`ifdef IEEE754_DIV_ROUND_EN
        run_op("div_1_3",     32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 28);
`else
        run_op("div_1_3",     32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 28);
`endif
        run_op("div_neg",     32'h3FC00000, 32'hBF000000, 32'hC0400000, 28);
        run_op("neg1_by_0",   32'hBF800000, 32'h00000000, 32'hFF800000, 1);
        run_op("zero_by_0",   32'h00000000, 32'h00000000, 32'h7FC00000, 1);
        run_op("overflow",    32'h7F000000, 32'h3E800000, 32'h7F800000, 28);
        run_op("underflow",   32'h00800000, 32'h4B000000, 32'h00000000, 28);
        run_op("nan_by_1",    32'hFFC00000, 32'h3F800000, 32'h7FC00000, 1);
        run_op("inf_by_inf",  32'h7F800000, 32'hFF800000, 32'h7FC00000, 1);
        run_op("inf_by_2",    32'hFF800000, 32'h40000000, 32'hFF800000, 1);
        run_op("one_by_inf",  32'h3F800000, 32'h7F800000, 32'h00000000, 1);
        run_op("denorm_ftz",  32'h00000001, 32'hBF800000, 32'h80000000, 1);

        // Back-pressure in DONE while a stray request sits on the input.
        out_ready = 1'b0;
        input_a   = 32'h40C00000;
        input_b   = 32'h40800000;
        in_valid  = 1'b1;
        cycle();
        input_a = 32'h3F800000;
        input_b = 32'h3F800000;
        lat = 1;
        while (!out_valid && lat < 60) begin
            cycle();
            lat++;
        end
        check_int("stall_latency", out_valid ? lat : -1, 28);
        check32("stall_result", result, 32'h3FC00000);
        hold_res = result;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check32("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check32("stall_result_hold", result, hold_res);
            check32("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        check32("release_out_valid", {31'd0, out_valid}, 32'd0);
        check32("release_in_ready", {31'd0, in_ready}, 32'd1);

        // Reset during DIVIDE abandons the operation.
        input_a  = 32'h40C00000;
        input_b  = 32'h40000000;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        repeat (9) cycle();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        check32("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        check32("midreset_result", result, 32'h00000000);
        check32("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        run_op("after_reset_6_2", 32'h40C00000, 32'h40000000, 32'h40400000, 28);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
